// File: rtl/vec_mem_pkg.sv
// rtl/vec_mem_pkg.sv - shared constants, opcodes and FSM state encoding for the vector memory stage
package vec_mem_pkg;

  localparam int DEF_LANES  = 8;
  localparam int DEF_LANE_W = 24;
  localparam int DEF_ADDR_W = 21;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_RSP  = 2'd2;

endpackage

// File: rtl/vec_mem_out_reg.sv
// rtl/vec_mem_out_reg.sv - result holding register with valid/ready handshake
module vec_mem_out_reg #(
  parameter int DW = 192
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          is_load_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          is_load_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          is_load_q, is_load_d;

  // A new result overrides the drain so a same-cycle handshake and reload keeps valid high.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    is_load_d = is_load_q;
    if (load_i) begin
      valid_d   = 1'b1;
      data_d    = data_i;
      is_load_d = is_load_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      is_load_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      is_load_q <= is_load_d;
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign is_load_o = is_load_q;

endmodule

// File: rtl/vec_mem_stage.sv
// rtl/vec_mem_stage.sv - single-outstanding vector load/store stage
// VEC_MEM_STAGE_LANE_MASK_EN adds in_mask and drives per-lane store enables.
module vec_mem_stage
  import vec_mem_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_mem,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic [LANES*LANE_W-1:0] in_data,
`ifdef VEC_MEM_STAGE_LANE_MASK_EN
  input  logic [LANES-1:0]        in_mask,
`endif
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LANES*LANE_W-1:0] mem_wdata,
  output logic [LANES-1:0]        mem_wmask,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [LANES*LANE_W-1:0] mem_rdata,
  output logic                    out_valid,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic                    out_is_load,
  input  logic                    out_ready,
  output logic                    err_illegal
);

  localparam int DW = LANES * LANE_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
`ifdef VEC_MEM_STAGE_LANE_MASK_EN
  logic [LANES-1:0]  wmask_q, wmask_d;
`endif

  logic          accept;
  logic          is_load_op;
  logic          is_store_op;
  logic          is_illegal;
  logic          res_load;
  logic [DW-1:0] res_data;
  logic          res_is_load;

  assign is_load_op  = in_mem[3] && (in_mem[2:0] == OP_LOAD);
  assign is_store_op = in_mem[3] && (in_mem[2:0] == OP_STORE);
  assign is_illegal  = in_mem[3] && !is_load_op && !is_store_op;

  assign in_ready = (state_q == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    err_d       = 1'b0;
    res_load    = 1'b0;
    res_data    = in_data;
    res_is_load = 1'b0;
`ifdef VEC_MEM_STAGE_LANE_MASK_EN
    wmask_d     = wmask_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_load_op || is_store_op) begin
            state_d = ST_REQ;
            addr_d  = in_addr;
            wdata_d = in_data;
            we_d    = is_store_op;
`ifdef VEC_MEM_STAGE_LANE_MASK_EN
            wmask_d = is_store_op ? in_mask : '1;
`endif
          end else begin
            // Illegal opcodes fall through as pass-through results.
            res_load = 1'b1;
            res_data = in_data;
            err_d    = is_illegal;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          if (we_q) begin
            res_load = 1'b1;
            res_data = wdata_q;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_RSP;
          end
        end
      end
      ST_RSP: begin
        if (mem_rvalid) begin
          res_load    = 1'b1;
          res_data    = mem_rdata;
          res_is_load = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef VEC_MEM_STAGE_LANE_MASK_EN
      wmask_q <= '1;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
`ifdef VEC_MEM_STAGE_LANE_MASK_EN
      wmask_q <= wmask_d;
`endif
    end
  end

  assign mem_req     = (state_q == ST_REQ);
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign err_illegal = err_q;
`ifdef VEC_MEM_STAGE_LANE_MASK_EN
  assign mem_wmask   = wmask_q;
`else
  assign mem_wmask   = '1;
`endif

  vec_mem_out_reg #(
    .DW (DW)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load_i    (res_load),
    .data_i    (res_data),
    .is_load_i (res_is_load),
    .ready_i   (out_ready),
    .valid_o   (out_valid),
    .data_o    (out_data),
    .is_load_o (out_is_load)
  );

endmodule
